// File: rtl/apb_cmd_queue.sv
// apb_cmd_queue: queues APB user-side commands, issues them one at a time and returns ordered responses
module apb_cmd_queue #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int CMD_DEPTH = 4,
  parameter int RSP_DEPTH = 4,
  parameter int TIMEOUT = 16
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic                    cmd_write,
  input  logic [ADDR_WIDTH-1:0]   cmd_addr,
  input  logic [DATA_WIDTH-1:0]   cmd_wdata,
  input  logic [DATA_WIDTH/8-1:0] cmd_strb,
  input  logic [2:0]              cmd_prot,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic                    rsp_write,
  output logic [DATA_WIDTH-1:0]   rsp_rdata,
  output logic                    rsp_master_error,
  output logic                    rsp_other_error,
  output logic                    rsp_timeout,
  output logic                    m_sel,
  output logic                    m_write,
  output logic [ADDR_WIDTH-1:0]   m_addr,
  output logic [DATA_WIDTH-1:0]   m_wdata,
  output logic [DATA_WIDTH/8-1:0] m_strb,
  output logic [2:0]              m_prot,
  input  logic                    m_ready,
  input  logic [DATA_WIDTH-1:0]   m_rdata,
  input  logic                    m_master_error,
  input  logic                    m_other_error,
  output logic                    busy
);
  localparam int SW = DATA_WIDTH / 8;
  localparam int CW = ADDR_WIDTH + DATA_WIDTH + SW + 4;
  localparam int RW = DATA_WIDTH + 4;
  localparam int CP = $clog2(CMD_DEPTH);
  localparam int RP = $clog2(RSP_DEPTH);
  localparam int TW = TIMEOUT > 1 ? $clog2(TIMEOUT + 1) : 1;
  typedef enum logic {IDLE, ACTIVE} state_t;
  state_t state, nxt;
  logic [CW-1:0] cmd_mem [CMD_DEPTH];
  logic [RW-1:0] rsp_mem [RSP_DEPTH];
  logic [CP-1:0] cmd_wp, cmd_rp;
  logic [RP-1:0] rsp_wp, rsp_rp;
  logic [CP:0] cmd_cnt;
  logic [RP:0] rsp_cnt;
  logic [TW-1:0] tcnt;
  logic cmd_push, issue, expire, done, rsp_pop;
  logic [RW-1:0] rsp_din, rsp_head;
  assign cmd_ready = cmd_cnt != (CP+1)'(CMD_DEPTH);
  assign cmd_push = cmd_valid && cmd_ready;
  assign issue = state == IDLE && cmd_cnt != '0 && rsp_cnt != (RP+1)'(RSP_DEPTH);
  assign expire = TIMEOUT != 0 && !m_ready && tcnt == TW'(TIMEOUT - 1);
  assign done = state == ACTIVE && (m_ready || expire);
  assign rsp_valid = rsp_cnt != '0;
  assign rsp_pop = rsp_valid && rsp_ready;
  assign rsp_din = {m_write, (m_ready && !m_write) ? m_rdata : {DATA_WIDTH{1'b0}},
                    m_ready && m_master_error, m_ready && m_other_error, !m_ready};
  assign rsp_head = rsp_valid ? rsp_mem[rsp_rp] : '0;
  assign {rsp_write, rsp_rdata, rsp_master_error, rsp_other_error, rsp_timeout} = rsp_head;
  assign m_sel = state == ACTIVE;
  assign busy = m_sel || cmd_cnt != '0 || rsp_valid;
  always_comb nxt = issue ? ACTIVE : done ? IDLE : state;
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) state <= IDLE;
    else state <= nxt;
  always_ff @(posedge clk) begin
    if (cmd_push) cmd_mem[cmd_wp] <= {cmd_write, cmd_addr, cmd_wdata, cmd_strb, cmd_prot};
    if (done) rsp_mem[rsp_wp] <= rsp_din;
  end
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      cmd_wp <= '0;
      cmd_rp <= '0;
      cmd_cnt <= '0;
      rsp_wp <= '0;
      rsp_rp <= '0;
      rsp_cnt <= '0;
      tcnt <= '0;
      {m_write, m_addr, m_wdata, m_strb, m_prot} <= '0;
    end else begin
      cmd_wp <= cmd_push ? cmd_wp + CP'(1) : cmd_wp;
      cmd_rp <= issue ? cmd_rp + CP'(1) : cmd_rp;
      cmd_cnt <= cmd_cnt + (CP+1)'(cmd_push) - (CP+1)'(issue);
      rsp_wp <= done ? rsp_wp + RP'(1) : rsp_wp;
      rsp_rp <= rsp_pop ? rsp_rp + RP'(1) : rsp_rp;
      rsp_cnt <= rsp_cnt + (RP+1)'(done) - (RP+1)'(rsp_pop);
      tcnt <= issue ? '0 : (m_sel && TIMEOUT != 0) ? tcnt + TW'(1) : tcnt;
      if (issue) {m_write, m_addr, m_wdata, m_strb, m_prot} <= cmd_mem[cmd_rp];
    end
endmodule
